// File: rtl/dmem_responder.sv
// dmem_responder: the memory-side end of the core's load/store port.
// It accepts one request at a time, holds it for WAIT_STATES cycles, then
// does a word access with byte-enable writes and returns the result.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_req_valid / o_req_ready  request handshake (ready only in IDLE)
//   i_req_write, i_req_addr    store/load select, byte address
//   i_req_wdata, i_req_be      store data and byte enables
//   o_rsp_valid / i_rsp_ready  response handshake
//   o_rsp_rdata, o_rsp_err     load data (0 for stores/errors), error flag
//
// State table
//   state  | meaning
//   IDLE   | ready for a request
//   BUSY   | request captured, counting down wait states
//   RESP   | access done, response held until accepted
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic        w_access;
  logic        w_acc_write;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_be;
  logic        w_in_range;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic        w_mem_we;

  assign w_accept = (r_state == S_IDLE) && i_req_valid;

  always_comb begin
    w_next   = r_state;
    w_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_next   = S_RESP;
            w_access = 1'b1;
          end else begin
            w_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_RESP;
          w_access = 1'b1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so the
  // live request is used; otherwise the captured copy is.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_write = i_req_write;
      w_acc_addr  = i_req_addr;
      w_acc_wdata = i_req_wdata;
      w_acc_be    = i_req_be;
    end else begin
      w_acc_write = r_write;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_be    = r_be;
    end
  end

  // BASE_ADDR is aligned to the array size, so the range check reduces to
  // matching the upper address bits and the index is just the low bits.
  assign w_in_range = (w_acc_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_err      = (w_acc_addr[1:0] != 2'b00) || !w_in_range;
  assign w_idx      = w_acc_addr[AW+1:2];
  // Reset gating keeps an access from landing while the FSM is held in reset.
  assign w_mem_we   = w_access && i_rst_n && w_acc_write && !w_err;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_be[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      o_req_ready <= (w_next == S_IDLE);
      o_rsp_valid <= (w_next == S_RESP);
      if (w_accept) begin
        r_write <= i_req_write;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_be    <= i_req_be;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        o_rsp_err   <= w_err;
        o_rsp_rdata <= (w_acc_write || w_err) ? 32'd0 : r_mem[w_idx];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port: the memory-side end of the address/write-data/read-data interface that the datapath drives.
- Accepts one request at a time over a valid/ready handshake and holds it for a programmable number of wait states.
- Performs the word access with byte-enable writes, then returns read data and an error flag over a valid/ready response channel.
- Sits between the core's memory-request adapter and the on-chip data RAM; used to exercise multicycle and stall paths.

Parameters:
- DEPTH, 256: number of 32-bit words in the array; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH*4.
- WAIT_STATES, 2: extra cycles between request acceptance and the memory access; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; bit i selects wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and on error.
- rsp_err  output  1  misaligned or out-of-range access.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (reset=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. The array is not cleared.
- IDLE: req_ready=1. On req_valid&&req_ready at an edge, capture write, addr, wdata and be.
  - If WAIT_STATES=0: go straight to RESP at that edge and perform the access at that edge.
  - Otherwise: go to BUSY with counter=WAIT_STATES-1.
- BUSY: req_ready=0. Counter decrements each cycle. At the edge where counter==0, perform the access and go to RESP.
- Latency: rsp_valid first seen high WAIT_STATES+1 cycles after the accepting edge.
- Access rules:
  - Error if addr[1:0]!=0, addr<BASE_ADDR, or addr>=BASE_ADDR+DEPTH*4. On error: no array write, rsp_rdata=0, rsp_err=1.
  - Word index = (addr-BASE_ADDR)>>2, using log2(DEPTH) bits.
  - Store writes only the enabled bytes and returns rsp_rdata=0. be=4'b0000 is a legal no-op store with rsp_err=0.
  - Load ignores be and returns the full word. The value reflects every store that completed before the load's access edge.
- RESP: rsp_valid=1; rsp_rdata and rsp_err stay stable until handshake.
  - On rsp_valid&&rsp_ready: go to IDLE; rsp_valid=0 next cycle.
  - req_ready returns to 1 in IDLE, so the minimum spacing between accepted requests is WAIT_STATES+2 cycles.
- req_valid while not in IDLE is ignored. The requester must hold its request until req_ready.
- Reset mid-operation:
  - In BUSY: the pending access is discarded and a pending store is never written.
  - In RESP: the already-committed store remains in the array; the response is dropped.
- Outputs are registered; no combinational path from req_* or rsp_ready to any output except none (req_ready depends on state only).

Test Plan:
- WAIT_STATES=2: store addr 0x10, wdata 0xDEADBEEF, be=4'hF accepted at cycle 0 -> rsp_valid at cycle 3, rsp_rdata=0, rsp_err=0. Then load 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte enables: word at 0x20 preloaded 0x11223344; store wdata 0xAABBCCDD with be=4'b0101 -> load 0x20 returns 0x11BB33DD.
- Errors: load 0x22 -> rsp_err=1, rdata=0. Store to BASE_ADDR+DEPTH*4 -> rsp_err=1 and word 0 unchanged.
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stable, req_ready=0 throughout. Raise rsp_ready -> IDLE next cycle.
- WAIT_STATES=0: back-to-back store then load to the same address with rsp_ready=1 -> each rsp_valid 1 cycle after acceptance, load returns the stored value, acceptances 2 cycles apart.
- Reset pulsed low during BUSY of a store to 0x30 (previously 0x0) -> outputs at reset values immediately; subsequent load 0x30 returns 0x00000000.
